// File: rtl/serial_word_deser.sv
// ---------------------------------------------------------------------------
// serial_word_deser
//   Multi-channel serial-to-parallel front end. Serial bits qualified by i_en
//   are framed into DATA_WIDTH-bit words using the i_din_valid end-of-word
//   strobe. Each completed word is tagged with a round-robin channel index and
//   presented on a valid/ready output register. Framing errors (strobe early or
//   missing) and overruns (output still full) raise one-cycle pulses.
//
// Parameters
//   DATA_WIDTH    bits per word (>=2)
//   NUM_CHANNELS  number of interleaved channels (>=1)
//   MSB_FIRST     0: first bit lands in bit 0; 1: first bit lands in MSB
//   CH_WIDTH      derived channel tag width
//
// Ports
//   i_clk         clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_en          bit strobe; i_din/i_din_valid sampled only when high
//   i_din         serial data bit
//   i_din_valid   marks the last bit of a word
//   o_word        parallel word
//   o_chan        channel tag of o_word
//   o_word_valid  o_word/o_chan valid
//   i_word_ready  consumer accepts when o_word_valid & i_word_ready
//   o_frame_err   one-cycle pulse: framing error, word dropped
//   o_overrun     one-cycle pulse: completed word dropped, output full
//
// Optional feature (macro SERIAL_WORD_DESER_ERR_CNT_EN)
//   o_err_cnt     16-bit saturating count of framing errors
//   o_ovr_cnt     16-bit saturating count of overruns
// ---------------------------------------------------------------------------
module serial_word_deser #(
  parameter int DATA_WIDTH   = 24,
  parameter int NUM_CHANNELS = 2,
  parameter bit MSB_FIRST    = 1'b0,
  localparam int CH_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_din,
  input  logic                  i_din_valid,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic [CH_WIDTH-1:0]   o_chan,
  output logic                  o_word_valid,
  input  logic                  i_word_ready,
  output logic                  o_frame_err,
`ifdef SERIAL_WORD_DESER_ERR_CNT_EN
  output logic                  o_overrun,
  output logic [15:0]           o_err_cnt,
  output logic [15:0]           o_ovr_cnt
`else
  output logic                  o_overrun
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CH_WIDTH-1:0] LAST_CH  = CH_WIDTH'(NUM_CHANNELS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                state_p0, state_d;
  logic [DATA_WIDTH-1:0] sr_p0, sr_d;
  logic [CNT_W-1:0]      bit_cnt_p0, bit_cnt_d;
  logic [CH_WIDTH-1:0]   chan_cnt_p0, chan_cnt_d;

  logic                  last_bit;
  logic                  word_done;
  logic                  frame_bad;
  logic                  load_out;
  logic                  drop_out;
  logic                  vld_d;

  logic [DATA_WIDTH-1:0] word_p1;
  logic [CH_WIDTH-1:0]   chan_p1;
  logic                  vld_p1;
  logic                  ferr_p1;
  logic                  ovr_p1;

  // Stage p0: bit framing, channel sequencing and output-register decision
  always_comb begin
    state_d    = state_p0;
    sr_d       = sr_p0;
    bit_cnt_d  = bit_cnt_p0;
    chan_cnt_d = chan_cnt_p0;
    last_bit   = (bit_cnt_p0 == LAST_BIT);
    word_done  = 1'b0;
    frame_bad  = 1'b0;
    load_out   = 1'b0;
    drop_out   = 1'b0;
    vld_d      = vld_p1 & ~i_word_ready;

    if (i_en) begin
      sr_d = MSB_FIRST ? {sr_p0[DATA_WIDTH-2:0], i_din}
                       : {i_din, sr_p0[DATA_WIDTH-1:1]};
      word_done = i_din_valid & last_bit;
      // Strobe before the last bit, or last bit without strobe.
      frame_bad = i_din_valid ^ last_bit;

      case (state_p0)
        S_IDLE: begin
          if (!(word_done || frame_bad)) begin
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (word_done || frame_bad) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (word_done || frame_bad) begin
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_p0 + CNT_W'(1);
      end

      if (word_done) begin
        if (!vld_p1 || i_word_ready) begin
          load_out = 1'b1;
        end else begin
          drop_out = 1'b1;
        end
        // Channel advances even on a dropped word so the sequence survives.
        chan_cnt_d = (chan_cnt_p0 == LAST_CH) ? '0 : chan_cnt_p0 + CH_WIDTH'(1);
      end

      if (frame_bad) begin
        chan_cnt_d = '0;
      end
    end

    if (load_out) begin
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_p0    <= S_IDLE;
      sr_p0       <= '0;
      bit_cnt_p0  <= '0;
      chan_cnt_p0 <= '0;
    end else begin
      state_p0    <= state_d;
      sr_p0       <= sr_d;
      bit_cnt_p0  <= bit_cnt_d;
      chan_cnt_p0 <= chan_cnt_d;
    end
  end

  // Stage p1: output word register and status pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      word_p1 <= '0;
      chan_p1 <= '0;
      vld_p1  <= 1'b0;
      ferr_p1 <= 1'b0;
      ovr_p1  <= 1'b0;
    end else begin
      if (load_out) begin
        word_p1 <= sr_d;
        chan_p1 <= chan_cnt_p0;
      end
      vld_p1  <= vld_d;
      ferr_p1 <= frame_bad;
      ovr_p1  <= drop_out;
    end
  end

  assign o_word       = word_p1;
  assign o_chan       = chan_p1;
  assign o_word_valid = vld_p1;
  assign o_frame_err  = ferr_p1;
  assign o_overrun    = ovr_p1;

`ifdef SERIAL_WORD_DESER_ERR_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] err_cnt_p1;
  logic [15:0] ovr_cnt_p1;

  // Stage p1: error counters update on the same edge that raises the pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_cnt_p1 <= '0;
      ovr_cnt_p1 <= '0;
    end else begin
      if (frame_bad) begin
        err_cnt_p1 <= sat_inc16(err_cnt_p1);
      end
      if (drop_out) begin
        ovr_cnt_p1 <= sat_inc16(ovr_cnt_p1);
      end
    end
  end

  assign o_err_cnt = err_cnt_p1;
  assign o_ovr_cnt = ovr_cnt_p1;
`endif

endmodule
